// File: rtl/ftc_pkg.sv
// ---------------------------------------------------------------------------
// ftc_pkg
// Shared types and constants for the fault_tolerant_control block.
//   ftc_state_e            : controller state (NORMAL / RETRY / SAFE)
//   FTC_MAX_RETRY_DEFAULT  : default number of faulted RETRY cycles allowed
// ---------------------------------------------------------------------------
package ftc_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        RETRY  = 2'd1,
        SAFE   = 2'd2
    } ftc_state_e;

    localparam int FTC_MAX_RETRY_DEFAULT = 3;

endpackage : ftc_pkg

// File: rtl/ftc_retry_counter.sv
// ---------------------------------------------------------------------------
// ftc_retry_counter
// Saturating retry counter with synchronous clear.
//   clk         : rising-edge clock
//   srst        : synchronous active-high reset (count -> 0)
//   clr         : clear count to 0 (wins over inc)
//   inc         : increment, holds once the terminal value is reached
//   at_terminal : count currently equals TERMINAL
// ---------------------------------------------------------------------------
module ftc_retry_counter #(
    parameter int CNT_W    = 2,
    parameter int TERMINAL = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic inc,
    output logic at_terminal
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign at_terminal = (cnt_reg == TERM_VAL);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && !at_terminal) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule : ftc_retry_counter

// File: rtl/fault_tolerant_control.sv
// ---------------------------------------------------------------------------
// fault_tolerant_control
// Gates the architectural write enables of the core on decode faults.
// Transient faults (illegal opcode / invalid control) squash the instruction
// and replay from pc_saved for a bounded number of cycles; a stuck-at fault
// or an exhausted retry budget latches SAFE (all writes off, NOP inserted)
// until reset.
//
// Ports
//   clk, reset                       : clock, synchronous active-high reset
//   illegal_opcode, invalid_control  : transient fault flags
//   stuck_at_fault                   : permanent fault flag (highest priority)
//   pc/reg/mem_write_normal          : enables from the normal control path
//   pc_current                       : normally computed next PC
//   pc_saved                         : replay target PC
//   pc/reg/mem_write_out             : gated enables
//   pc_next                          : PC to load
//   insert_nop                       : squash current instruction
//   retry_en                         : replay from pc_saved this cycle
// Outputs are combinational from registered state and current inputs.
// ---------------------------------------------------------------------------
module fault_tolerant_control
    import ftc_pkg::*;
#(
    parameter int MAX_RETRY = FTC_MAX_RETRY_DEFAULT,
    parameter int CNT_W     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        illegal_opcode,
    input  logic        invalid_control,
    input  logic        stuck_at_fault,
    input  logic        pc_write_normal,
    input  logic        reg_write_normal,
    input  logic        mem_write_normal,
    input  logic [31:0] pc_current,
    input  logic [31:0] pc_saved,
    output logic        pc_write_out,
    output logic        reg_write_out,
    output logic        mem_write_out,
    output logic [31:0] pc_next,
    output logic        insert_nop,
    output logic        retry_en
);

    ftc_state_e state_reg;
    ftc_state_e state_next;

    logic tf;
    logic cnt_inc;
    logic cnt_clr;
    logic cnt_at_terminal;

    assign tf = illegal_opcode | invalid_control;

    // The count only advances on consecutive faulted RETRY cycles; any other
    // cycle (entering RETRY, leaving it, SAFE) restarts it from zero.
    assign cnt_inc = (state_reg == RETRY) && tf && !stuck_at_fault;
    assign cnt_clr = !cnt_inc;

    ftc_retry_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (MAX_RETRY - 1)
    ) u_retry_counter (
        .clk         (clk),
        .srst        (reset),
        .clr         (cnt_clr),
        .inc         (cnt_inc),
        .at_terminal (cnt_at_terminal)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= NORMAL;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (stuck_at_fault) begin
            state_next = SAFE;
        end else begin
            unique case (state_reg)
                NORMAL:  state_next = tf ? RETRY : NORMAL;
                RETRY: begin
                    if (!tf) begin
                        state_next = NORMAL;
                    end else if (cnt_at_terminal) begin
                        state_next = SAFE;
                    end else begin
                        state_next = RETRY;
                    end
                end
                SAFE:    state_next = SAFE;
                default: state_next = SAFE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decoder
    // ------------------------------------------------------------------
    logic       pass_mode;
    logic       retry_mode;
    logic       safe_mode;
    logic [2:0] normal_we;
    logic [2:0] gated_we;

    assign safe_mode  = !reset && ((state_reg == SAFE) || stuck_at_fault);
    assign retry_mode = !reset && !safe_mode && tf;
    assign pass_mode  = !reset && !safe_mode && !tf;

    assign normal_we = {mem_write_normal, reg_write_normal, pc_write_normal};

    // Normal enables reach the core only in pass-through.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_we_gate
            assign gated_we[gi] = pass_mode & normal_we[gi];
        end
    endgenerate

    always_comb begin
        pc_write_out  = gated_we[0];
        reg_write_out = gated_we[1];
        mem_write_out = gated_we[2];
        pc_next       = pc_current;
        insert_nop    = 1'b0;
        retry_en      = 1'b0;
        if (safe_mode) begin
            insert_nop = 1'b1;
        end else if (retry_mode) begin
            // Replay forces the PC write so the saved PC is reloaded.
            pc_write_out = 1'b1;
            pc_next      = pc_saved;
            insert_nop   = 1'b1;
            retry_en     = 1'b1;
        end
    end

endmodule : fault_tolerant_control

// File: tb/tb_fault_tolerant_control.sv
// ---------------------------------------------------------------------------
// tb_fault_tolerant_control
// Directed vectors for fault_tolerant_control (MAX_RETRY=3). The driver
// applies one vector per cycle and queues its hand-computed response; an
// independent monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_fault_tolerant_control;

    localparam logic [31:0] PC_SAVED = 32'h0000_0008;

    logic        clk;
    logic        reset;
    logic        illegal_opcode;
    logic        invalid_control;
    logic        stuck_at_fault;
    logic        pc_write_normal;
    logic        reg_write_normal;
    logic        mem_write_normal;
    logic [31:0] pc_current;
    logic [31:0] pc_saved;
    logic        pc_write_out;
    logic        reg_write_out;
    logic        mem_write_out;
    logic [31:0] pc_next;
    logic        insert_nop;
    logic        retry_en;

    fault_tolerant_control #(
        .MAX_RETRY (3),
        .CNT_W     (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .illegal_opcode   (illegal_opcode),
        .invalid_control  (invalid_control),
        .stuck_at_fault   (stuck_at_fault),
        .pc_write_normal  (pc_write_normal),
        .reg_write_normal (reg_write_normal),
        .mem_write_normal (mem_write_normal),
        .pc_current       (pc_current),
        .pc_saved         (pc_saved),
        .pc_write_out     (pc_write_out),
        .reg_write_out    (reg_write_out),
        .mem_write_out    (mem_write_out),
        .pc_next          (pc_next),
        .insert_nop       (insert_nop),
        .retry_en         (retry_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        pc_w;
        logic        reg_w;
        logic        mem_w;
        logic [31:0] pcn;
        logic        nop;
        logic        rty;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   vec   = 0;

    // Hand-labelled response templates
    function automatic exp_t e_rst(logic [31:0] pcc);
        exp_t e;
        e.idx = 0; e.pc_w = 0; e.reg_w = 0; e.mem_w = 0;
        e.pcn = pcc; e.nop = 0; e.rty = 0;
        return e;
    endfunction

    function automatic exp_t e_safe(logic [31:0] pcc);
        exp_t e;
        e.idx = 0; e.pc_w = 0; e.reg_w = 0; e.mem_w = 0;
        e.pcn = pcc; e.nop = 1; e.rty = 0;
        return e;
    endfunction

    function automatic exp_t e_retry();
        exp_t e;
        e.idx = 0; e.pc_w = 1; e.reg_w = 0; e.mem_w = 0;
        e.pcn = PC_SAVED; e.nop = 1; e.rty = 1;
        return e;
    endfunction

    function automatic exp_t e_pass(logic [2:0] n, logic [31:0] pcc);
        exp_t e;
        e.idx = 0; e.pc_w = n[0]; e.reg_w = n[1]; e.mem_w = n[2];
        e.pcn = pcc; e.nop = 0; e.rty = 0;
        return e;
    endfunction

    // Drive one vector just after the rising edge and queue its response.
    // n = {mem, reg, pc} normal enables.
    task automatic drive(input logic rst, input logic ill, input logic inv,
                         input logic stk, input logic [2:0] n,
                         input logic [31:0] pcc, input exp_t e);
        @(posedge clk);
        #1;
        reset            = rst;
        illegal_opcode   = ill;
        invalid_control  = inv;
        stuck_at_fault   = stk;
        pc_write_normal  = n[0];
        reg_write_normal = n[1];
        mem_write_normal = n[2];
        pc_current       = pcc;
        vec++;
        e.idx = vec;
        sb.push_back(e);
    endtask

    // Monitor: the combinational outputs are presented every cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (pc_write_out !== e.pc_w || reg_write_out !== e.reg_w ||
                mem_write_out !== e.mem_w || pc_next !== e.pcn ||
                insert_nop !== e.nop || retry_en !== e.rty) begin
                bad++;
                $display("FAIL vec%0d: got pcw=%b regw=%b memw=%b pc_next=%h nop=%b retry=%b ; want pcw=%b regw=%b memw=%b pc_next=%h nop=%b retry=%b",
                         e.idx, pc_write_out, reg_write_out, mem_write_out, pc_next,
                         insert_nop, retry_en, e.pc_w, e.reg_w, e.mem_w, e.pcn, e.nop, e.rty);
            end else begin
                $display("vec%0d ok: pcw=%b regw=%b memw=%b pc_next=%h nop=%b retry=%b",
                         e.idx, pc_write_out, reg_write_out, mem_write_out, pc_next,
                         insert_nop, retry_en);
            end
        end
    end

    localparam logic [31:0] P10 = 32'h0000_0010;
    localparam logic [31:0] P24 = 32'h0000_0024;

    initial begin
        reset = 1; illegal_opcode = 0; invalid_control = 0; stuck_at_fault = 0;
        pc_write_normal = 1; reg_write_normal = 1; mem_write_normal = 1;
        pc_current = P10; pc_saved = PC_SAVED;
        repeat (2) @(posedge clk);

        // Reset, then pass-through
        drive(1, 0, 0, 0, 3'b111, P10, e_rst(P10));
        drive(0, 0, 0, 0, 3'b111, P10, e_pass(3'b111, P10));
        drive(0, 0, 0, 0, 3'b101, P24, e_pass(3'b101, P24));
        drive(0, 0, 0, 0, 3'b010, P10, e_pass(3'b010, P10));

        // Two-cycle illegal opcode, then pass-through in NORMAL
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 0, 0, 0, 3'b111, P10, e_pass(3'b111, P10));

        // Held 1+MAX_RETRY cycles -> SAFE, sticky after fault clears
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P24, e_safe(P24));
        drive(0, 0, 0, 0, 3'b111, P10, e_safe(P10));

        // Reset out of SAFE with a transient fault present
        drive(1, 1, 0, 0, 3'b111, P10, e_rst(P10));
        drive(0, 0, 0, 0, 3'b111, P10, e_pass(3'b111, P10));

        // Stuck-at rises mid-retry: immediate SAFE outputs
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 1, 3'b111, P10, e_safe(P10));
        drive(0, 0, 0, 0, 3'b111, P10, e_safe(P10));
        drive(0, 0, 0, 0, 3'b111, P24, e_safe(P24));

        // Reset released with faults clear
        drive(1, 1, 0, 0, 3'b111, P10, e_rst(P10));
        drive(0, 0, 0, 0, 3'b111, P10, e_pass(3'b111, P10));

        // invalid_control alone behaves like illegal_opcode
        drive(0, 0, 1, 0, 3'b111, P10, e_retry());
        drive(0, 0, 0, 0, 3'b111, P10, e_pass(3'b111, P10));

        // Interrupted retry run restarts the budget
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 0, 1, 0, 3'b111, P10, e_retry());
        drive(0, 1, 1, 0, 3'b111, P10, e_retry());
        drive(0, 0, 0, 0, 3'b110, P10, e_pass(3'b110, P10));
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_safe(P10));

        // Reset mid-RETRY clears the count
        drive(1, 0, 0, 0, 3'b111, P10, e_rst(P10));
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(1, 1, 0, 0, 3'b111, P24, e_rst(P24));
        drive(0, 0, 0, 0, 3'b111, P10, e_pass(3'b111, P10));
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 1, 0, 0, 3'b111, P10, e_retry());
        drive(0, 0, 0, 0, 3'b111, P10, e_safe(P10));

        // Stuck-at alone from NORMAL, and fault+stuck together
        drive(1, 0, 0, 0, 3'b111, P10, e_rst(P10));
        drive(0, 0, 0, 1, 3'b111, P24, e_safe(P24));
        drive(0, 0, 0, 0, 3'b111, P10, e_safe(P10));
        drive(1, 0, 0, 0, 3'b111, P10, e_rst(P10));
        drive(0, 0, 1, 1, 3'b111, P10, e_safe(P10));
        drive(0, 0, 0, 0, 3'b111, P10, e_safe(P10));

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fault_tolerant_control

// File: doc/fault_tolerant_control.md
# fault_tolerant_control

Control-path fault handler sitting between the main decoder/PC logic and the architectural write enables of the RISC-V core. Classifies decode-stage faults as transient (illegal opcode, invalid control) or permanent (stuck-at). Transient faults are handled by squashing the instruction and replaying it from a saved PC, with a bounded number of attempts. Permanent faults, or exhausted retries, latch the core into a safe halt state until reset.

## Interface
- `MAX_RETRY`, default 3: consecutive faulted retry cycles allowed before escalating to SAFE; legal range 1..255.
- `CNT_W`, default 2: retry counter width; must satisfy 2^CNT_W > MAX_RETRY-1, i.e. hold 0..MAX_RETRY-1.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `illegal_opcode`  in  1  transient fault: undecodable opcode.
- `invalid_control`  in  1  transient fault: inconsistent control word.
- `stuck_at_fault`  in  1  permanent fault; highest priority.
- `pc_write_normal`  in  1  PC write enable from normal control.
- `reg_write_normal`  in  1  register-file write enable from normal control.
- `mem_write_normal`  in  1  data-memory write enable from normal control.
- `pc_current`  in  32  normally computed next PC.
- `pc_saved`  in  32  PC of the faulting instruction, used as the replay target.
- `pc_write_out`  out  1  gated PC write enable.
- `reg_write_out`  out  1  gated register write enable.
- `mem_write_out`  out  1  gated memory write enable.
- `pc_next`  out  32  PC value to load.
- `insert_nop`  out  1  squash the current instruction into a NOP.
- `retry_en`  out  1  replay from `pc_saved` is active this cycle.

## Operation
- Define `tf = illegal_opcode | invalid_control`.
- Registered state: `state` ∈ {NORMAL, RETRY, SAFE} and `retry_cnt[CNT_W-1:0]`.
- All outputs are combinational from the registered state and the current inputs. Decode mode in priority order:
  1. `reset` high: all enables 0, `insert_nop`=0, `retry_en`=0, `pc_next`=`pc_current`.
  2. `state`==SAFE or `stuck_at_fault`: `pc_write_out`=`reg_write_out`=`mem_write_out`=0, `insert_nop`=1, `retry_en`=0, `pc_next`=`pc_current`.
  3. `tf` (state NORMAL or RETRY): `reg_write_out`=`mem_write_out`=0, `pc_write_out`=1, `pc_next`=`pc_saved`, `insert_nop`=1, `retry_en`=1.
  4. Otherwise: pass-through. `*_write_out`=`*_write_normal`, `pc_next`=`pc_current`, `insert_nop`=0, `retry_en`=0.
- Next-state rules, evaluated on each clock edge:
  - `reset`: state NORMAL, count 0. Overrides everything, including SAFE.
  - `stuck_at_fault` from any state: SAFE.
  - SAFE is sticky; it is left only via `reset`.
  - NORMAL with `tf`: RETRY, count←0.
  - NORMAL without `tf`: stay NORMAL.
  - RETRY with `tf`: if count==MAX_RETRY-1, go to SAFE; else count←count+1.
  - RETRY without `tf`: NORMAL, count←0.
- A simultaneous `tf` and `stuck_at_fault` resolves as stuck: SAFE outputs, no retry.
- Deasserting `stuck_at_fault` does not clear SAFE.

## Timing
- Output latency: zero cycles (combinational) for fault gating. State changes take effect in the following cycle.
- Retry budget: `tf` held continuously gives 1 cycle in NORMAL plus MAX_RETRY cycles in RETRY with `retry_en`=1. SAFE outputs follow on the next cycle.
- Reset state is NORMAL with count 0. First post-reset cycle with no faults is pass-through.
- Reset asserted mid-RETRY or in SAFE: outputs go to the reset values immediately; state is NORMAL on the next edge.

## Structure
- Shared package `ftc_pkg`: state enum (NORMAL=2'd0, RETRY=2'd1, SAFE=2'd2) and the default MAX_RETRY constant.
- Optional sub-module `ftc_retry_counter`: saturating counter with clear, increment, and terminal-count output. Everything else is a single FSM plus an output decoder.

## Test plan
- Reset then no faults, normals=1, `pc_current`=0x10 → all `*_write_out`=1, `pc_next`=0x10, `insert_nop`=0, `retry_en`=0.
- `illegal_opcode` pulsed for 2 cycles, `pc_saved`=0x08 → `retry_en`=1, `insert_nop`=1, `pc_next`=0x08, reg/mem writes 0 for both cycles, then pass-through resumes in state NORMAL.
- `illegal_opcode` held 1+MAX_RETRY cycles (4) → 4 retry cycles, then SAFE: all enables 0, `insert_nop`=1. SAFE persists after the fault is removed.
- `illegal_opcode` active, `stuck_at_fault` rises mid-retry → same cycle: `retry_en`=0, `pc_write_out`=0, `pc_next`=0x10. SAFE persists after both faults clear.
- In SAFE with `illegal_opcode`=1, assert `reset` for 1 cycle, then release with faults clear → reset outputs during reset, pass-through afterward.
- `invalid_control` alone for 1 cycle → identical response to `illegal_opcode`.
